// File: rtl/lsu_mem_if_pkg.sv
// Shared definitions for the load/store unit memory interface.
//   - ALU_* operation codes for the load/store opcodes (plus one non-memory code)
//   - lsu_req_t: the request captured at the core handshake
//   - helpers that classify an opcode and derive its access width and split rule
package lsu_mem_if_pkg;

    localparam logic [5:0] ALU_ADD = 6'h01;  // representative non-memory code
    localparam logic [5:0] ALU_LB  = 6'h10;
    localparam logic [5:0] ALU_LH  = 6'h11;
    localparam logic [5:0] ALU_LW  = 6'h12;
    localparam logic [5:0] ALU_LBU = 6'h14;
    localparam logic [5:0] ALU_LHU = 6'h15;
    localparam logic [5:0] ALU_SB  = 6'h18;
    localparam logic [5:0] ALU_SH  = 6'h19;
    localparam logic [5:0] ALU_SW  = 6'h1A;

    typedef struct packed {
        logic [5:0]  alucode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_load(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
               (code == ALU_LBU) || (code == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    function automatic logic is_mem(input logic [5:0] code);
        return is_load(code) || is_store(code);
    endfunction

    // Byte-enable pattern of the access before lane shifting.
    function automatic logic [3:0] size_mask(input logic [5:0] code);
        case (code)
            ALU_LB, ALU_LBU, ALU_SB: return 4'b0001;
            ALU_LH, ALU_LHU, ALU_SH: return 4'b0011;
            default:                 return 4'b1111;
        endcase
    endfunction

    // True when the access straddles a word boundary and needs a second beat.
    function automatic logic needs_split(input logic [5:0] code, input logic [1:0] off);
        case (code)
            ALU_LH, ALU_LHU, ALU_SH: return off == 2'd3;
            ALU_LW, ALU_SW:          return off != 2'd0;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Word-organised data memory request/response bus.
//   req/we/be/addr/wdata : initiator -> memory, held until gnt
//   gnt                  : memory accepted the request this cycle
//   rvalid/rdata         : one in-order response per granted access
interface lsu_mem_if_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   off, size, wdata -> be64 (byte enables over a two-word window) and d64
//                       (store data shifted into its byte lanes)
//   lo, hi, off, alucode -> ldata (load bytes realigned and extended)
// Only hi[23:0] is taken: with off <= 3 the top byte of the second word is
// never part of the result.
module lsu_lane_align
    import lsu_mem_if_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [23:0] hi,
    input  logic [5:0]  alucode,
    output logic [7:0]  be64,
    output logic [63:0] d64,
    output logic [31:0] ldata
);

    logic [4:0]  shamt;
    logic [31:0] v;

    assign shamt = {off, 3'b000};
    assign be64  = {4'b0000, size} << off;
    assign d64   = {32'd0, wdata} << shamt;

    // {hi,lo} >> 8*off, written per offset
    always_comb begin
        v = lo;
        case (off)
            2'd0: v = lo;
            2'd1: v = {hi[7:0],  lo[31:8]};
            2'd2: v = {hi[15:0], lo[31:16]};
            2'd3: v = {hi[23:0], lo[31:24]};
            default: v = lo;
        endcase
    end

    // Non-load codes return zero so stores complete with rsp_rdata = 0.
    always_comb begin
        ldata = '0;
        case (alucode)
            ALU_LB:  ldata = {{24{v[7]}}, v[7:0]};
            ALU_LH:  ldata = {{16{v[15]}}, v[15:0]};
            ALU_LW:  ldata = v;
            ALU_LBU: ldata = {24'd0, v[7:0]};
            ALU_LHU: ldata = {16'd0, v[15:0]};
            default: ldata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit front end to the word-organised data memory.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_*             : byte-addressed load/store request from execute
//                       (req_ready only in IDLE)
//   rsp_valid/rdata   : one-cycle completion pulse with extended load data
//   mem (master)      : word-aligned memory bus, one access outstanding
// Word-crossing halfword/word accesses are issued as two consecutive beats.
module lsu_mem_if
    import lsu_mem_if_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_alucode,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    lsu_mem_if_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1
    } state_t;

    state_t      state, state_nx;
    lsu_req_t    cur;
    logic [31:0] lo_q;
    logic [1:0]  off;
    logic        split, st, fire_rsp;
    logic [31:0] word0, word1, lo_in;
    logic [23:0] hi_in;
    logic [7:0]  be64;
    logic [63:0] d64;
    logic [31:0] ldata;

    assign off   = cur.addr[1:0];
    assign split = needs_split(cur.alucode, off);
    assign st    = is_store(cur.alucode);
    assign word0 = {cur.addr[31:2], 2'b00};
    assign word1 = word0 + 32'd4;  // wraps past 0xFFFFFFFC

    // The response word is fed straight in on the completing beat so the
    // result can be registered in the same edge; hi is zero unless split.
    assign lo_in = (state == S_WAIT0) ? mem.rdata : lo_q;
    assign hi_in = (state == S_WAIT1) ? mem.rdata[23:0] : 24'd0;

    lsu_lane_align u_align (
        .off     (off),
        .size    (size_mask(cur.alucode)),
        .wdata   (cur.wdata),
        .lo      (lo_in),
        .hi      (hi_in),
        .alucode (cur.alucode),
        .be64    (be64),
        .d64     (d64),
        .ldata   (ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Bus outputs decode from state and the captured request only, so they
    // are naturally stable while a request waits for gnt.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        fire_rsp  = 1'b0;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.be    = 4'h0;
        mem.addr  = 32'd0;
        mem.wdata = 32'd0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && is_mem(req_alucode)) state_nx = S_REQ0;
            end
            S_REQ0: begin
                mem.req   = 1'b1;
                mem.we    = st;
                mem.addr  = word0;
                mem.be    = st ? be64[3:0] : 4'hF;
                mem.wdata = st ? d64[31:0] : 32'd0;
                if (mem.gnt) state_nx = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem.rvalid) begin
                    state_nx = split ? S_REQ1 : S_IDLE;
                    fire_rsp = !split;
                end
            end
            S_REQ1: begin
                mem.req   = 1'b1;
                mem.we    = st;
                mem.addr  = word1;
                mem.be    = st ? be64[7:4] : 4'hF;
                mem.wdata = st ? d64[63:32] : 32'd0;
                if (mem.gnt) state_nx = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem.rvalid) begin
                    state_nx = S_IDLE;
                    fire_rsp = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            lo_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (req_valid && req_ready) begin
                cur <= '{alucode: req_alucode, addr: req_addr, wdata: req_wdata};
                // Non-memory codes complete on the next cycle with zero data.
                if (!is_mem(req_alucode)) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (state == S_WAIT0 && mem.rvalid && is_load(cur.alucode)) lo_q <= mem.rdata;
            if (fire_rsp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ldata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: byte-level memory model predicts each access
// and each response; a responder emulates the memory with programmable grant
// and response delays.
module tb_lsu_mem_if;
    import lsu_mem_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_alucode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    lsu_mem_if_if mbus();

    lsu_mem_if dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_alucode (req_alucode),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem         (mbus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    int checks = 0;
    int errors = 0;
    acc_t        exp_acc[$];
    acc_t        acc_log[$];
    logic [31:0] exp_rsp[$];
    bit [31:0]   mw [bit [31:0]];   // responder's word memory
    bit [7:0]    mb [bit [31:0]];   // model's byte memory
    int gnt_delay = 0;
    int rv_delay  = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit [7:0] rdb(input bit [31:0] a);
        return mb.exists(a) ? mb[a] : 8'h00;
    endfunction

    function automatic bit [31:0] rdw(input bit [31:0] a);
        return mw.exists(a) ? mw[a] : 32'h0;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        mw[a] = d;
        for (int k = 0; k < 4; k++) mb[a + 32'(k)] = d[8*k +: 8];
    endtask

    // Predict accesses and the response from byte-level semantics.
    task automatic model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic [31:0] w0, wl, v;
        logic [63:0] d64;
        acc_t e;
        if (!is_mem(code)) begin
            exp_rsp.push_back(32'h0);
            return;
        end
        n   = (code == ALU_LB || code == ALU_LBU || code == ALU_SB) ? 1 :
              (code == ALU_LH || code == ALU_LHU || code == ALU_SH) ? 2 : 4;
        w0  = a & ~32'd3;
        wl  = (a + 32'(n - 1)) & ~32'd3;
        d64 = {32'd0, wd} << (8 * a[1:0]);
        for (int j = 0; j < ((wl != w0) ? 2 : 1); j++) begin
            e.addr  = w0 + 32'(4 * j);
            e.we    = is_store(code);
            e.be    = 4'h0;
            e.wdata = j ? d64[63:32] : d64[31:0];
            for (int k = 0; k < n; k++) begin
                logic [31:0] ba;
                ba = a + 32'(k);
                if ((ba & ~32'd3) == e.addr) e.be[ba[1:0]] = 1'b1;
            end
            if (!e.we) e.be = 4'hF;
            exp_acc.push_back(e);
        end
        if (is_store(code)) begin
            for (int k = 0; k < n; k++) mb[a + 32'(k)] = wd[8*k +: 8];
            exp_rsp.push_back(32'h0);
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = rdb(a + 32'(k));
            if (code == ALU_LB && v[7])  v = v | 32'hFFFFFF00;
            if (code == ALU_LH && v[15]) v = v | 32'hFFFF0000;
            exp_rsp.push_back(v);
        end
    endtask

    // Memory responder: grants after gnt_delay waiting cycles, answers
    // rv_delay cycles after the grant, checks held outputs and each access.
    initial begin
        int wait_cnt, pend_cnt;
        logic [31:0] pend_data;
        acc_t cur, held, e;
        bit holding;
        wait_cnt = 0; pend_cnt = 0; pend_data = 0; holding = 0;
        mbus.gnt = 0; mbus.rvalid = 0; mbus.rdata = 0;
        forever begin
            @(posedge clk); #1;
            mbus.rvalid = 0; mbus.rdata = 0; mbus.gnt = 0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mbus.rvalid = 1;
                    mbus.rdata  = pend_data;
                end
            end
            if (mbus.req === 1'b1) begin
                cur.addr = mbus.addr; cur.we = mbus.we; cur.be = mbus.be; cur.wdata = mbus.wdata;
                if (holding) begin
                    chk("hold_addr",  cur.addr,  held.addr);
                    chk("hold_be",    {28'd0, cur.be}, {28'd0, held.be});
                    chk("hold_we",    {31'd0, cur.we}, {31'd0, held.we});
                    chk("hold_wdata", cur.wdata, held.wdata);
                end
                if (wait_cnt >= gnt_delay) begin
                    mbus.gnt = 1; wait_cnt = 0; holding = 0;
                    acc_log.push_back(cur);
                    if (exp_acc.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access: got addr 0x%08h expected none", cur.addr);
                    end else begin
                        e = exp_acc.pop_front();
                        chk("acc_addr", cur.addr, e.addr);
                        chk("acc_we", {31'd0, cur.we}, {31'd0, e.we});
                        chk("acc_be", {28'd0, cur.be}, {28'd0, e.be});
                        if (e.we) chk("acc_wdata", cur.wdata, e.wdata);
                    end
                    pend_data = rdw(cur.addr);
                    if (cur.we) begin
                        bit [31:0] w;
                        w = rdw(cur.addr);
                        for (int k = 0; k < 4; k++) if (cur.be[k]) w[8*k +: 8] = cur.wdata[8*k +: 8];
                        mw[cur.addr] = w;
                    end
                    pend_cnt = rv_delay;
                end else begin
                    wait_cnt++; holding = 1; held = cur;
                end
            end else begin
                wait_cnt = 0; holding = 0;
            end
        end
    end

    // Compare process: every response against the model, rdata held between.
    initial begin
        logic [31:0] last;
        last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                chk("rst_mem_req", {31'd0, mbus.req}, 32'd0);
                last = 0;
            end else if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h expected no response", rsp_rdata);
                end else chk("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
                last = rsp_rdata;
            end else chk("rsp_hold", rsp_rdata, last);
        end
    end

    task automatic do_req(input logic [5:0] code, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        int n;
        model(code, a, wd);
        @(negedge clk);
        req_valid = 1; req_alucode = code; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 80);
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_valid in %0d cycles expected one", lat);
        end
        rd = rsp_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat, l0;
        acc_t e;
        rst_n = 1; req_valid = 0; req_alucode = 0; req_addr = 0; req_wdata = 0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_req",   {31'd0, mbus.req}, 32'd0);
        chk("reset_mem_we",    {31'd0, mbus.we}, 32'd0);
        chk("reset_mem_be",    {28'd0, mbus.be}, 32'd0);
        chk("reset_mem_addr",  mbus.addr, 32'd0);
        chk("reset_mem_wdata", mbus.wdata, 32'd0);

        // aligned LW, best-case latency
        poke(32'h100, 32'hDEADBEEF);
        l0 = acc_log.size();
        do_req(ALU_LW, 32'h100, 0, rd, lat);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_latency", lat, 3);
        chk("lw_num_acc", acc_log.size() - l0, 1);
        chk("lw_acc_addr", acc_log[l0].addr, 32'h100);
        chk("lw_acc_be", {28'd0, acc_log[l0].be}, 32'hF);

        // byte loads with sign/zero extension
        poke(32'h100, 32'h80FF0000);
        do_req(ALU_LB, 32'h103, 0, rd, lat);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        do_req(ALU_LBU, 32'h103, 0, rd, lat);
        chk("lbu_rdata", rd, 32'h00000080);

        // split SW
        l0 = acc_log.size();
        do_req(ALU_SW, 32'h101, 32'h11223344, rd, lat);
        chk("sw_latency", lat, 5);
        chk("sw_num_acc", acc_log.size() - l0, 2);
        e = acc_log[l0];
        chk("sw_a0_addr", e.addr, 32'h100);
        chk("sw_a0_be", {28'd0, e.be}, 32'hE);
        chk("sw_a0_wdata", e.wdata, 32'h22334400);
        e = acc_log[l0 + 1];
        chk("sw_a1_addr", e.addr, 32'h104);
        chk("sw_a1_be", {28'd0, e.be}, 32'h1);
        chk("sw_a1_wdata", e.wdata, 32'h00000011);
        do_req(ALU_LW, 32'h101, 0, rd, lat);
        chk("lw_split_rdata", rd, 32'h11223344);
        chk("lw_split_latency", lat, 5);

        // LH wrapping past the top of the address space
        poke(32'hFFFFFFFC, 32'hAB000000);
        poke(32'h0, 32'h000000CD);
        l0 = acc_log.size();
        do_req(ALU_LH, 32'hFFFFFFFF, 0, rd, lat);
        chk("lh_wrap_rdata", rd, 32'hFFFFCDAB);
        chk("lh_wrap_a0_addr", acc_log[l0].addr, 32'hFFFFFFFC);
        chk("lh_wrap_a1_addr", acc_log[l0 + 1].addr, 32'h0);

        // non-memory code
        l0 = acc_log.size();
        do_req(ALU_ADD, 32'h100, 32'h55, rd, lat);
        chk("nonmem_rdata", rd, 32'h0);
        chk("nonmem_latency", lat, 1);
        chk("nonmem_no_acc", acc_log.size() - l0, 0);

        // withheld grants and slower responses
        gnt_delay = 3; rv_delay = 2;
        do_req(ALU_SH, 32'h203, 32'h1234BEEF, rd, lat);
        do_req(ALU_LHU, 32'h203, 0, rd, lat);
        chk("lhu_split_rdata", rd, 32'h0000BEEF);
        do_req(ALU_LH, 32'h203, 0, rd, lat);
        chk("lh_split_rdata", rd, 32'hFFFFBEEF);
        do_req(ALU_SB, 32'h106, 32'hFFFFFFA5, rd, lat);
        do_req(ALU_LB, 32'h106, 0, rd, lat);
        chk("lb_after_sb", rd, 32'hFFFFFFA5);
        do_req(ALU_LW, 32'h202, 0, rd, lat);
        gnt_delay = 0; rv_delay = 1;
        do_req(ALU_LHU, 32'h102, 0, rd, lat);
        do_req(ALU_SW, 32'h300, 32'hCAFEF00D, rd, lat);

        // reset while waiting for the response; stale rvalid arrives later
        rv_delay = 4;
        e.addr = 32'h300; e.we = 0; e.be = 4'hF; e.wdata = 0;
        exp_acc.push_back(e);
        @(negedge clk);
        req_valid = 1; req_alucode = ALU_LW; req_addr = 32'h300; req_wdata = 0;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #2 rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("abort_mem_req", {31'd0, mbus.req}, 32'd0);
        end
        rv_delay = 1;
        do_req(ALU_LW, 32'h300, 0, rd, lat);
        chk("post_reset_lw", rd, 32'hCAFEF00D);
        chk("post_reset_latency", lat, 3);
        do_req(ALU_LW, 32'h101, 0, rd, lat);
        chk("post_reset_split_lw", rd, 32'h11223344);

        repeat (3) @(negedge clk);
        chk("acc_queue_empty", exp_acc.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
